smac_acc_seq: RTL

- Sequencer for the AC2 accumulation datapath of the SMAC engine.
- Accepts a job of N blocks. For each block it:
  - clears AC2;
  - accepts exactly PW partial products from the multiplier stage, loading AC2 on each one;
  - presents the finished AC2 sum downstream through a valid/ready handshake.
- Sits between the top-level job controller and the AC2 register plus its enable logic.

---
 rtl/smac_ctrl_pkg.sv | 20 ++
 rtl/smac_acc_seq_if.sv | 42 ++++
 rtl/smac_beat_cnt.sv | 46 ++++
 rtl/smac_acc_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/smac_ctrl_pkg.sv
// Shared types and width helpers for the SMAC AC2 accumulation sequencer.
package smac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } acc_state_t;

  function automatic int beat_w(input int pw);
    return $clog2(pw) + 1;
  endfunction

  function automatic int blk_w(input int nblk);
    return $clog2(nblk) + 1;
  endfunction

endpackage

// File: rtl/smac_acc_seq_if.sv
// Job, partial-product and result handshake bundle of smac_acc_seq.
// The abort line exists only when SMAC_ACC_ABORT_EN is defined.
interface smac_acc_seq_if #(
  parameter int NBLK = 8
) ();
  import smac_ctrl_pkg::*;

  localparam int BW = blk_w(NBLK);

  logic          start;
  logic [BW-1:0] n_blk;
  logic          busy;
  logic          pp_valid;
  logic          pp_ready;
  logic          ac2_en;
  logic          ac2_clr;
  logic [BW-1:0] blk_idx;
  logic          res_valid;
  logic          res_ready;
  logic          done;
`ifdef SMAC_ACC_ABORT_EN
  logic          abort;

  modport slave (
    input  start, n_blk, pp_valid, res_ready, abort,
    output busy, pp_ready, ac2_en, ac2_clr, blk_idx, res_valid, done
  );
  modport master (
    output start, n_blk, pp_valid, res_ready, abort,
    input  busy, pp_ready, ac2_en, ac2_clr, blk_idx, res_valid, done
  );
`else
  modport slave (
    input  start, n_blk, pp_valid, res_ready,
    output busy, pp_ready, ac2_en, ac2_clr, blk_idx, res_valid, done
  );
  modport master (
    output start, n_blk, pp_valid, res_ready,
    input  busy, pp_ready, ac2_en, ac2_clr, blk_idx, res_valid, done
  );
`endif
endinterface

// File: rtl/smac_beat_cnt.sv
// Beat counter running 1..PW: clear loads 1, increment wraps to 1 after PW.
module smac_beat_cnt
  import smac_ctrl_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int            CW    = beat_w(PW);
  localparam logic [CW-1:0] ONE_V = CW'(32'd1);
  localparam logic [CW-1:0] PW_V  = CW'(PW);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == PW_V);

  // next beat value
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = ONE_V;
    end else if (inc) begin
      if (last) begin
        cnt_d = ONE_V;
      end else begin
        cnt_d = cnt_q + ONE_V;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // beat register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= ONE_V;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/smac_acc_seq.sv
// AC2 accumulation sequencer: per block clear AC2, accept PW partial products, hand the sum on.
// Optional job abort is built in with SMAC_ACC_ABORT_EN.
module smac_acc_seq
  import smac_ctrl_pkg::*;
#(
  parameter int PW   = 4,
  parameter int NBLK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  smac_acc_seq_if.slave bus
);
  localparam int            BW     = blk_w(NBLK);
  localparam logic [BW-1:0] NBLK_V = BW'(NBLK);
  localparam logic [BW-1:0] ZERO_V = BW'(32'd0);
  localparam logic [BW-1:0] ONE_V  = BW'(32'd1);

  acc_state_t    state_q, state_d;
  logic          busy_q, busy_d;
  logic          pp_ready_q, pp_ready_d;
  logic          ac2_clr_q, ac2_clr_d;
  logic          res_valid_q, res_valid_d;
  logic          done_q, done_d;
  logic [BW-1:0] blk_idx_q, blk_idx_d;
  logic [BW-1:0] nblk_q, nblk_d;
  logic          beat_clr, beat_inc, beat_last;
  logic          pp_fire, res_fire, abort_s;

`ifdef SMAC_ACC_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  assign pp_fire  = bus.pp_valid & pp_ready_q;
  assign res_fire = res_valid_q & bus.res_ready;

  smac_beat_cnt #(.PW(PW)) u_beat (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (beat_clr),
    .inc  (beat_inc),
    .last (beat_last)
  );

  // next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    busy_d      = 1'b0;
    pp_ready_d  = 1'b0;
    ac2_clr_d   = 1'b0;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
    blk_idx_d   = blk_idx_q;
    nblk_d      = nblk_q;
    beat_clr    = 1'b0;
    beat_inc    = 1'b0;
    // abort overrides any handshake in the same cycle; nothing is counted
    if (abort_s && busy_q) begin
      state_d   = FIN;
      done_d    = 1'b1;
      ac2_clr_d = 1'b1;
      blk_idx_d = ZERO_V;
      beat_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.n_blk == ZERO_V) begin
              state_d = FIN;
              done_d  = 1'b1;
            end else begin
              state_d   = CLEAR;
              busy_d    = 1'b1;
              ac2_clr_d = 1'b1;
              blk_idx_d = ZERO_V;
              nblk_d    = (bus.n_blk > NBLK_V) ? NBLK_V : bus.n_blk;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          state_d    = ACCUM;
          busy_d     = 1'b1;
          pp_ready_d = 1'b1;
          beat_clr   = 1'b1;
        end
        ACCUM: begin
          busy_d = 1'b1;
          if (pp_fire) begin
            beat_inc = 1'b1;
            if (beat_last) begin
              state_d     = OUT;
              res_valid_d = 1'b1;
            end else begin
              pp_ready_d = 1'b1;
            end
          end else begin
            pp_ready_d = 1'b1;
          end
        end
        OUT: begin
          if (res_fire) begin
            if (blk_idx_q == nblk_q - ONE_V) begin
              state_d   = FIN;
              done_d    = 1'b1;
              blk_idx_d = ZERO_V;
            end else begin
              state_d   = CLEAR;
              busy_d    = 1'b1;
              ac2_clr_d = 1'b1;
              blk_idx_d = blk_idx_q + ONE_V;
            end
          end else begin
            busy_d      = 1'b1;
            res_valid_d = 1'b1;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state, job context and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      pp_ready_q  <= 1'b0;
      ac2_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      blk_idx_q   <= ZERO_V;
      nblk_q      <= ZERO_V;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      pp_ready_q  <= pp_ready_d;
      ac2_clr_q   <= ac2_clr_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      blk_idx_q   <= blk_idx_d;
      nblk_q      <= nblk_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.pp_ready  = pp_ready_q;
  assign bus.ac2_en    = pp_fire;
  assign bus.ac2_clr   = ac2_clr_q;
  assign bus.blk_idx   = blk_idx_q;
  assign bus.res_valid = res_valid_q;
  assign bus.done      = done_q;

endmodule
